// File: rtl/wb_master_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arbiter_rr
// Purpose  : Round-robin arbiter that shares one Wishbone slave bus between
//            NUM_MASTERS Wishbone masters. A grant is held for the whole
//            m_cyc_i transaction. After the transaction there is one dead
//            cycle, and then the next master is chosen in round-robin order.
// Ports    : wb_clk_i/wb_rst_i         - clock, synchronous active-high reset
//            m_cyc/stb/we/adr/dat/sel  - packed master requests
//            m_dat_o/m_ack_o/m_err_o   - read data broadcast; ack and err go
//                                        to the granted master only
//            s_*                       - the shared slave bus
//            grant_o                   - one-hot grant, for status and debug
// Option   : WB_ARB_TIMEOUT_EN - a watchdog that ends a strobe left
//            unanswered for TIMEOUT cycles with a one-cycle err
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [DATA_W-1:0]               s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  output logic [NUM_MASTERS-1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int LW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [LW-1:0]          last, last_nxt;

  // Bus fields of the granted master, taken before the optional watchdog gating
  logic                   sel_cyc, sel_stb, sel_we;
  logic [ADDR_W-1:0]      sel_adr;
  logic [DATA_W-1:0]      sel_dat;
  logic [SEL_W-1:0]       sel_sel;
  logic                   ack_beat, err_beat;

  // Request vector copied twice, so that a right shift by last+1 puts the
  // requesters into round-robin search order starting at bit 0
  logic [2*NUM_MASTERS-1:0] req_rot;
  logic                     found;
  int                       pick;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    req_rot   = {m_cyc_i, m_cyc_i} >> (int'(last) + 1);
    found     = 1'b0;
    pick      = 0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          last_nxt  = LW'((int'(last) + 1 + pick) % NUM_MASTERS);
          grant_nxt = NUM_MASTERS'(1) << last_nxt;
        end
      end
      BUSY: begin
        // The granted master ended its cycle; release the bus for one dead cycle
        if ((m_cyc_i & grant) == '0) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // One-hot AND-OR mux. With no grant, every field stays 0.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant[k]) begin
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        sel_we  = m_we_i[k];
        sel_adr = m_adr_i[k*ADDR_W +: ADDR_W];
        sel_dat = m_dat_i[k*DATA_W +: DATA_W];
        sel_sel = m_sel_i[k*SEL_W +: SEL_W];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] wd_cnt;
  logic          wd_hit;

  // When the limit is reached, the beat is ended: stb is withdrawn, the
  // master receives err, and a late slave ack in the same cycle is dropped.
  assign wd_hit   = sel_stb && (wd_cnt == CW'(TIMEOUT));
  assign s_stb_o  = sel_stb & ~wd_hit;
  assign ack_beat = s_ack_i & ~wd_hit;
  assign err_beat = s_err_i | wd_hit;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !s_stb_o || s_ack_i || s_err_i) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign s_stb_o        = sel_stb;
  assign ack_beat       = s_ack_i;
  assign err_beat       = s_err_i;
`endif

  assign s_cyc_o = sel_cyc;
  assign s_we_o  = sel_we;
  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;
  assign s_sel_o = sel_sel;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant & {NUM_MASTERS{ack_beat}};
  assign m_err_o = grant & {NUM_MASTERS{err_beat}};
  assign grant_o = grant;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arbiter_rr
// Purpose  : Directed bench for wb_master_arbiter_rr with two masters. It
//            covers reset, arbitration latency, the dead cycle, bus routing,
//            grant holding over several beats, alternation between the two
//            masters, reset in the middle of a beat, and the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack, m_err, grant;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_master_arbiter_rr #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int err_cnt;
    int first_err;
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_cyc", s_cyc, 1'b0);
    chk("rst_stb", s_stb, 1'b0);
    chk("rst_ack", m_ack, 2'b00);
    chk("rst_err", m_err, 2'b00);

    // Test 1: both masters request at once; master 0 wins, then one dead cycle
    m_cyc = 2'b11; m_stb = 2'b11;
    #1 chk("t1_no_grant_yet", grant, 2'b00);
    step();
    chk("t1_grant0", grant, 2'b01);
    chk("t1_scyc", s_cyc, 1'b1);
    s_ack = 1'b1; s_dat_i = 32'hCAFE0001;
    #1 chk("t1_ack0", m_ack, 2'b01);
    chk("t1_mdat", m_dat_o, 32'hCAFE0001);
    step();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1 chk("t1_scyc_drop", s_cyc, 1'b0);
    step();
    chk("t1_dead", grant, 2'b00);
    step();
    chk("t1_grant1", grant, 2'b10);

    // Test 2: write from master 1 is routed to the slave; ack/err go to master 1
    m_we[1] = 1'b1; m_adr[63:32] = 32'h10; m_dat[63:32] = 32'hDEADBEEF; m_sel[7:4] = 4'hF;
    #1;
    chk("t2_adr", s_adr, 32'h10);
    chk("t2_dat", s_dat_o, 32'hDEADBEEF);
    chk("t2_sel", s_sel, 4'hF);
    chk("t2_we", s_we, 1'b1);
    chk("t2_stb", s_stb, 1'b1);
    s_ack = 1'b1;
    #1 chk("t2_ack1", m_ack, 2'b10);
    s_ack = 1'b0; s_err = 1'b1;
    #1 chk("t2_err1", m_err, 2'b10);
    chk("t2_noack", m_ack, 2'b00);
    s_err = 1'b0;
    step();
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    step();
    chk("t2_release", grant, 2'b00);

    // Test 3: master 0 holds its cycle over 4 beats while master 1 waits
    m_cyc = 2'b11;
    step();
    chk("t3_grant0", grant, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m_stb[0] = 1'b1; s_ack = 1'b1;
      #1 chk("t3_beat_ack", m_ack, 2'b01);
      step();
      chk("t3_hold", grant, 2'b01);
    end
    s_ack = 1'b0; m_stb = 2'b00; m_cyc[0] = 1'b0;
    step();
    chk("t3_dead", grant, 2'b00);
    step();
    chk("t3_grant1", grant, 2'b10);
    m_cyc = 2'b00;
    step();

    // Test 4: both masters request back to back; the grants alternate
    m_cyc = 2'b11;
    for (int t = 0; t < 8; t++) begin
      step();
      chk("t4_alt", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
      m_cyc = (t % 2 == 0) ? 2'b10 : 2'b01;
      step();
      chk("t4_dead", grant, 2'b00);
      m_cyc = 2'b11;
    end
    m_cyc = 2'b00;
    step();

    // Test 5: reset in the middle of a beat from master 0
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    chk("t5_grant0", grant, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0; s_ack = 1'b1;
    #1;
    chk("t5_scyc", s_cyc, 1'b0);
    chk("t5_grant", grant, 2'b00);
    chk("t5_ack_dropped", m_ack, 2'b00);
    s_ack = 1'b0; m_cyc = 2'b11;
    step();
    chk("t5_last_reset", grant, 2'b01);
    m_cyc = 2'b00; m_stb = 2'b00;
    step(); step();

    // Test 6: the slave never acks
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    chk("t6_grant0", grant, 2'b01);
    err_cnt = 0; first_err = -1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k <= 20; k++) begin
      if (m_err[0]) begin
        err_cnt++;
        if (first_err < 0) begin
          first_err = k;
          chk("t6_stb_forced_low", s_stb, 1'b0);
        end
      end
      step();
    end
    chk("t6_err_cycle", first_err, 16);
    chk("t6_err_count", err_cnt, 1);
    chk("t6_grant_kept", grant, 2'b01);
`else
    for (int k = 0; k < 1000; k++) begin
      if (m_err != 2'b00) err_cnt++;
      step();
    end
    chk("t6_no_err", err_cnt, 0);
    chk("t6_stb_held", s_stb, 1'b1);
`endif
    m_cyc = 2'b00; m_stb = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
